// File: rtl/conv_out_pool.sv
// 2:1 max-pool, ReLU and round-and-shift requantize of the conv y stream to OUT_W bits.
// Pairs never straddle a frame; an odd frame's final sample is pooled alone.
module conv_out_pool #(
    parameter int IN_W      = 21,
    parameter int OUT_W     = 8,
    parameter int FRAME_LEN = 97,
    parameter int SHIFT     = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [OUT_W-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int INT_W = IN_W + 1;
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [INT_W-1:0] ROUND    = INT_W'(2 ** (SHIFT - 1));
    localparam logic signed [INT_W-1:0] OUT_MAX  = INT_W'(2 ** (OUT_W - 1) - 1);

    typedef enum logic {
        EMPTY,
        HAVE_FIRST
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         in_cnt_reg, in_cnt_next;
    logic signed [IN_W-1:0]   pair_reg, pair_next;
    logic signed [OUT_W-1:0]  out_reg, out_next;
    logic                     valid_reg, valid_next;

    logic                     completing_slot;
    logic                     accept;
    logic                     complete;
    logic signed [INT_W-1:0]  sample_ext;
    logic signed [INT_W-1:0]  pair_ext;
    logic signed [INT_W-1:0]  max_val;
    logic signed [INT_W-1:0]  relu_val;
    logic signed [INT_W-1:0]  rounded;
    logic signed [INT_W-1:0]  quot;
    logic signed [OUT_W-1:0]  out_val;

    // Ready only drops on a slot that would produce an output while one is still unread.
    assign completing_slot = (state_reg == HAVE_FIRST) || (in_cnt_reg == LAST_IDX);
    assign s_ready_y       = !completing_slot || !valid_reg || m_ready_z;
    assign accept          = s_valid_y && s_ready_y;
    assign complete        = accept && completing_slot;

    assign m_data_out_z = out_reg;
    assign m_valid_z    = valid_reg;

    always_comb begin
        sample_ext = {s_data_in_y[IN_W-1], s_data_in_y};
        pair_ext   = {pair_reg[IN_W-1], pair_reg};
        max_val    = ((state_reg == HAVE_FIRST) && (pair_ext > sample_ext)) ? pair_ext : sample_ext;
        relu_val   = max_val[INT_W-1] ? '0 : max_val;
        rounded    = relu_val + ROUND;
        quot       = rounded >>> SHIFT;
        out_val    = (quot > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : quot[OUT_W-1:0];
    end

    always_comb begin
        state_next  = state_reg;
        in_cnt_next = in_cnt_reg;
        pair_next   = pair_reg;
        out_next    = out_reg;
        valid_next  = valid_reg;

        if (accept) begin
            in_cnt_next = (in_cnt_reg == LAST_IDX) ? '0 : in_cnt_reg + CNT_W'(1);
            if (completing_slot) begin
                state_next = EMPTY;
            end else begin
                state_next = HAVE_FIRST;
                pair_next  = s_data_in_y;
            end
        end

        // A load in the same cycle as a drain keeps valid high with the new value.
        if (complete) begin
            out_next   = out_val;
            valid_next = 1'b1;
        end else if (m_ready_z) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= EMPTY;
            in_cnt_reg <= '0;
            pair_reg   <= '0;
            out_reg    <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            in_cnt_reg <= in_cnt_next;
            pair_reg   <= pair_next;
            out_reg    <= out_next;
            valid_reg  <= valid_next;
        end
    end

endmodule

// File: tb/tb_conv_out_pool.sv
// Scoreboarded bench for conv_out_pool: stimulus pushes expected z values, a monitor
// pops and compares on every output handshake.
module tb_conv_out_pool;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [20:0] s_data_in_y;
    logic               s_valid_y;
    logic               s_ready_y;
    logic signed [7:0]  m_data_out_z;
    logic               m_valid_z;
    logic               m_ready_z;

    logic rand_mode;
    logic rdy_fixed;
    logic rand_bit;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic signed [7:0] expq[$];
    logic signed [7:0] got[0:1023];

    int m_cnt;
    bit m_have;
    int m_first;

    always #5 clk = ~clk;

    assign m_ready_z = rand_mode ? rand_bit : rdy_fixed;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    conv_out_pool dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z)
    );

    function automatic logic signed [7:0] ref_z(input int m);
        int r;
        r = (m < 0) ? 0 : m;
        r = (r + 1024) / 2048;
        if (r > 127) r = 127;
        return 8'(r);
    endfunction

    function automatic void model_accept(input int v);
        if (m_have) begin
            expq.push_back(ref_z((m_first > v) ? m_first : v));
            m_have = 0;
        end else if (m_cnt == 96) begin
            expq.push_back(ref_z(v));
        end else begin
            m_first = v;
            m_have  = 1;
        end
        m_cnt = (m_cnt == 96) ? 0 : m_cnt + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one line per output transaction.
    always @(negedge clk) begin
        if (reset && m_valid_z && m_ready_z) begin
            logic signed [7:0] e;
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL z_unexpected: got %0d, expected no output", m_data_out_z);
            end else begin
                e = expq.pop_front();
                if (m_data_out_z !== e) begin
                    n_bad++;
                    $display("FAIL z[%0d]: got %0d, expected %0d", n_out, m_data_out_z, e);
                end else begin
                    $display("z[%0d] = %0d", n_out, m_data_out_z);
                end
            end
            if (n_out < 1024) got[n_out] = m_data_out_z;
            n_out++;
        end
    end

    task automatic send(input int v, output int waits);
        bit ok;
        ok          = 0;
        waits       = 0;
        s_data_in_y = 21'(v);
        s_valid_y   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready_y) begin
                ok = 1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        if (ok) model_accept(v);
        else check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid_y   = 1'b0;
        s_data_in_y = 'x;
    endtask

    task automatic send_gap(input int v, input bit gaps);
        int w;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        send(v, w);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !m_valid_z) begin
                done = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check(name, int'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        expq.delete();
        m_cnt  = 0;
        m_have = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int base;
        bit stuck;

        reset       = 1'b0;
        s_valid_y   = 1'b0;
        s_data_in_y = 'x;
        rand_mode   = 1'b0;
        rdy_fixed   = 1'b1;
        m_cnt       = 0;
        m_have      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(m_valid_z), 0);
        check("rst_data", int'(m_data_out_z), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_ready", int'(s_ready_y), 1);
        @(posedge clk);
        #1;

        // Two-frame golden stream with downstream always ready.
        base = n_out;
        for (int i = 0; i < 97; i++) send(177328 - 1552 * i, w);
        for (int i = 0; i < 97; i++) send(-5000 - 1552 * i, w);
        wait_drain("golden_drain");
        check("golden_count", n_out - base, 98);
        check("golden_z0", int'(got[base]), 87);
        check("golden_z1", int'(got[base + 1]), 85);
        check("golden_z48_tail", int'(got[base + 48]), 14);
        check("golden_z49", int'(got[base + 49]), 0);
        check("golden_z97", int'(got[base + 97]), 0);
        stuck = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_valid_z) stuck = 1;
        end
        check("golden_idle_valid", int'(stuck), 0);
        @(posedge clk);
        #1;

        // Saturation, ReLU and rounding.
        do_reset();
        base = n_out;
        send(300000, w);
        send(-5, w);
        send(-1048576, w);
        send(-1, w);
        send(1023, w);
        send(1024, w);
        wait_drain("sat_drain");
        check("sat_z", int'(got[base]), 127);
        check("relu_z", int'(got[base + 1]), 0);
        check("round_z", int'(got[base + 2]), 1);

        // Backpressure with a pending output.
        do_reset();
        rdy_fixed = 1'b0;
        send(5000, w);
        send(3000, w);
        send(200000, w);
        check("bp_first_accept_waits", w, 0);
        s_data_in_y = 21'(100);
        s_valid_y   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", int'(s_ready_y), 0);
            check("bp_hold_valid", int'(m_valid_z), 1);
            check("bp_hold_data", int'(m_data_out_z), 2);
            @(posedge clk);
            #1;
        end
        rdy_fixed = 1'b1;
        @(negedge clk);
        check("bp_ready_release", int'(s_ready_y), 1);
        model_accept(100);
        @(posedge clk);
        #1;
        s_valid_y   = 1'b0;
        s_data_in_y = 'x;
        @(negedge clk);
        check("bp_nobubble_valid", int'(m_valid_z), 1);
        check("bp_nobubble_data", int'(m_data_out_z), 98);
        @(posedge clk);
        #1;
        wait_drain("bp_drain");

        // Random valid/ready over four frames.
        do_reset();
        rand_mode = 1'b1;
        base = n_out;
        for (int i = 0; i < 4 * 97; i++) begin
            int v;
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 400000)) - 150000;
            else v = int'($urandom_range(0, 2097151)) - 1048576;
            send_gap(v, 1'b1);
        end
        wait_drain("rand_drain");
        check("rand_count", n_out - base, 196);
        rand_mode = 1'b0;
        rdy_fixed = 1'b1;

        // Asynchronous reset mid-pair with an unread output.
        do_reset();
        rdy_fixed = 1'b0;
        send(10, w);
        send(20, w);
        send(30, w);
        check("rst5_pending", int'(m_valid_z), 1);
        reset = 1'b0;
        #1;
        check("rst5_async_valid", int'(m_valid_z), 0);
        check("rst5_async_data", int'(m_data_out_z), 0);
        expq.delete();
        m_cnt  = 0;
        m_have = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        base = n_out;
        for (int i = 0; i < 97; i++) send(2048 * i, w);
        wait_drain("rst5_drain");
        check("rst5_count", n_out - base, 49);
        check("rst5_first", int'(got[base]), 1);
        check("rst5_tail", int'(got[base + 48]), 96);

        // X on the data bus while idle must never reach the output.
        send(50000, w);
        repeat (3) begin
            @(negedge clk);
            check("x_idle_out", int'($isunknown(m_data_out_z)), 0);
        end
        @(posedge clk);
        #1;
        send(60000, w);
        repeat (3) begin
            @(negedge clk);
            check("x_idle_out", int'($isunknown(m_data_out_z)), 0);
        end
        @(posedge clk);
        #1;
        wait_drain("x_drain");
        check("x_pair_z", int'(got[n_out - 1]), 29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
